univ_shreg: RTL and testbench

UNIV_SHREG -- requirements
Module: univ_shreg

---
 rtl/univ_shreg_pkg.sv | 8 +
 rtl/shreg_bitcnt.sv | 18 +
 rtl/univ_shreg.sv | 73 +++++++
 tb/tb_univ_shreg.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/univ_shreg_pkg.sv
// univ_shreg_pkg: mode encoding and FSM state type shared by the shift register.
package univ_shreg_pkg;
    localparam logic [1:0] MODE_SR = 2'b00;
    localparam logic [1:0] MODE_SL = 2'b01;
    localparam logic [1:0] MODE_RR = 2'b10;
    localparam logic [1:0] MODE_RL = 2'b11;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/shreg_bitcnt.sv
// shreg_bitcnt: loadable down-counter with a zero flag for burst length tracking.
module shreg_bitcnt #(
    parameter int CNTW = 4
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            ld,
    input  logic            dec,
    input  logic [CNTW-1:0] din,
    output logic            zero
);
    logic [CNTW-1:0] cnt;
    always_ff @(posedge clk or negedge clr)
        if (!clr) cnt <= '0;
        else if (ld) cnt <= din;
        else if (dec) cnt <= cnt - CNTW'(1);
    assign zero = cnt == '0;
endmodule

// File: rtl/univ_shreg.sv
// univ_shreg: universal shift/rotate register with single-step and automatic burst shifting.
module univ_shreg
    import univ_shreg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] dpl,
    input  logic [1:0]       mode,
    input  logic             sft,
    input  logic             start,
    input  logic [CNTW-1:0]  nbits,
    input  logic             ph_low,
    input  logic             pl_high,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);
    state_t           state;
    logic [1:0]       mode_l;
    logic [1:0]       eff_mode;
    logic [WIDTH-1:0] q_sh;
    logic             cnt_zero;
    logic             cnt_ld;
    logic             cnt_dec;
    always_comb begin
        eff_mode = state == IDLE ? mode : mode_l;
        q_sh     = eff_mode == MODE_SR ? {ph_low, q[WIDTH-1:1]} :
                   eff_mode == MODE_SL ? {q[WIDTH-2:0], pl_high} :
                   eff_mode == MODE_RR ? {q[0], q[WIDTH-1:1]} :
                                         {q[WIDTH-2:0], q[WIDTH-1]};
        ser_out  = eff_mode[0] ? q[WIDTH-1] : q[0];
    end
    assign busy = state == SHIFT;
    assign done = state == DONE;
    // counter holds shifts remaining after the current one, so zero marks the last shift
    assign cnt_ld  = !load && state == IDLE && start && nbits != '0;
    assign cnt_dec = !load && state == SHIFT && !cnt_zero;
    shreg_bitcnt #(.CNTW(CNTW)) u_cnt (
        .clk  (clk),
        .clr  (clr),
        .ld   (cnt_ld),
        .dec  (cnt_dec),
        .din  (nbits - CNTW'(1)),
        .zero (cnt_zero)
    );
    always_ff @(posedge clk or negedge clr)
        if (!clr) begin
            q      <= '0;
            state  <= IDLE;
            mode_l <= '0;
        end else if (load) begin
            q     <= dpl;
            state <= IDLE;
        end else
            case (state)
                IDLE:
                    if (start) begin
                        mode_l <= mode;
                        state  <= nbits == '0 ? DONE : SHIFT;
                    end else if (sft)
                        q <= q_sh;
                SHIFT: begin
                    q <= q_sh;
                    if (cnt_zero) state <= DONE;
                end
                default: state <= IDLE;
            endcase
endmodule

// File: tb/tb_univ_shreg.sv
// tb_univ_shreg: directed and randomized checks of univ_shreg against a behavioural model.
module tb_univ_shreg;
    logic       clk = 0, clr = 0, load = 0, sft = 0, start = 0, ph_low = 0, pl_high = 0;
    logic [7:0] dpl = 0;
    logic [1:0] mode = 0;
    logic [3:0] nbits = 0;
    logic [7:0] q;
    logic       ser_out, busy, done;
    int checks = 0, errors = 0;
    bit cmp_en = 0;

    univ_shreg #(.WIDTH(8)) dut (
        .clk(clk), .clr(clr), .load(load), .dpl(dpl), .mode(mode), .sft(sft),
        .start(start), .nbits(nbits), .ph_low(ph_low), .pl_high(pl_high),
        .q(q), .ser_out(ser_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // model: register value, shifts still owed by the burst, pending done pulse
    logic [7:0] mq;
    int         mrem;
    bit         mdone;
    logic [1:0] mmode;

    function automatic logic [7:0] sh(input logic [7:0] v, input logic [1:0] m, input logic ph, input logic pl);
        int x;
        x = int'(v);
        case (m)
            2'd0:    x = x / 2 + (ph ? 128 : 0);
            2'd1:    x = (x * 2) % 256 + (pl ? 1 : 0);
            2'd2:    x = x / 2 + (x % 2) * 128;
            default: x = (x * 2) % 256 + x / 128;
        endcase
        return 8'(x);
    endfunction

    always @(posedge clk or negedge clr)
        if (!clr) begin
            mq <= 0; mrem <= 0; mdone <= 0; mmode <= 0;
        end else if (load) begin
            mq <= dpl; mrem <= 0; mdone <= 0;
        end else if (mrem > 0) begin
            mq <= sh(mq, mmode, ph_low, pl_high);
            mrem <= mrem - 1;
            mdone <= (mrem == 1);
        end else if (mdone)
            mdone <= 0;
        else if (start) begin
            mmode <= mode;
            mrem  <= int'(nbits);
            mdone <= (nbits == 0);
        end else if (sft)
            mq <= sh(mq, mode, ph_low, pl_high);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk)
        if (cmp_en) begin
            logic [1:0] m;
            m = (mrem > 0 || mdone) ? mmode : mode;
            chk("q", 32'(q), 32'(mq));
            chk("busy", 32'(busy), 32'(mrem > 0));
            chk("done", 32'(done), 32'(mdone));
            chk("ser_out", 32'(ser_out), (m == 2'd1 || m == 2'd3) ? 32'(mq / 128) : 32'(mq % 2));
        end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    logic [7:0] e033 [3] = '{8'hD2, 8'hE9, 8'hF4};
    int busyc;

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("reset_q", 32'(q), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        cmp_en = 1;
        clr = 1;
        step();
        // shift right burst of 3 with fill 1
        load = 1; dpl = 8'hA5; step(); load = 0;
        chk("load_a5", 32'(q), 32'h A5);
        start = 1; mode = 2'd0; nbits = 3; ph_low = 1; step(); start = 0;
        chk("033_busy0", 32'(busy), 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("033_q", 32'(q), 32'(e033[i]));
            chk("033_busy", 32'(busy), 32'(i < 2));
        end
        chk("033_done", 32'(done), 1);
        chk("model_033", 32'(mq), 32'h F4);
        step();
        chk("033_done_end", 32'(done), 0);
        // rotate left by one
        load = 1; dpl = 8'h81; step(); load = 0;
        start = 1; mode = 2'd3; nbits = 1; step(); start = 0;
        step();
        chk("034_q", 32'(q), 32'h03);
        chk("034_done", 32'(done), 1);
        chk("034_ser", 32'(ser_out), 0);
        step();
        chk("034_done_end", 32'(done), 0);
        chk("034_ser_idle", 32'(ser_out), 0);
        // shift left 8 with zero fill empties the register
        load = 1; dpl = 8'hA5; step(); load = 0;
        start = 1; mode = 2'd1; pl_high = 0; nbits = 8; step(); start = 0;
        busyc = int'(busy);
        for (int i = 0; i < 8; i++) begin
            step();
            busyc += int'(busy);
        end
        chk("035_busy_cycles", 32'(busyc), 8);
        chk("035_q", 32'(q), 0);
        chk("035_done", 32'(done), 1);
        chk("model_035", 32'(mq), 0);
        // zero-length burst
        load = 1; dpl = 8'h5A; step(); load = 0;
        nbits = 0; start = 1; step(); start = 0;
        chk("036_busy", 32'(busy), 0);
        chk("036_done", 32'(done), 1);
        chk("036_q", 32'(q), 32'h5A);
        step();
        chk("036_done_end", 32'(done), 0);
        // load aborts burst, then async clear aborts burst
        load = 1; dpl = 8'h55; step(); load = 0;
        start = 1; mode = 2'd0; nbits = 5; step(); start = 0;
        step();
        load = 1; dpl = 8'h3C; step(); load = 0;
        chk("037_q", 32'(q), 32'h3C);
        chk("037_busy", 32'(busy), 0);
        chk("037_done", 32'(done), 0);
        step();
        chk("037_no_done", 32'(done), 0);
        start = 1; nbits = 6; step(); start = 0;
        step();
        #2 clr = 0;
        #1;
        chk("037_clr_q", 32'(q), 0);
        chk("037_clr_busy", 32'(busy), 0);
        chk("037_clr_done", 32'(done), 0);
        step();
        chk("037_clr_hold", 32'(q), 0);
        clr = 1;
        step();
        // single-step rotate right, then start ignored during a burst
        load = 1; dpl = 8'h0F; step(); load = 0;
        sft = 1; mode = 2'd2; step(); sft = 0;
        chk("038_q", 32'(q), 32'h87);
        start = 1; mode = 2'd0; ph_low = 0; nbits = 4; step(); start = 0;
        mode = 2'd1; step();
        start = 1; nbits = 1; step(); start = 0;
        step();
        chk("038_mid_busy", 32'(busy), 1);
        step();
        chk("038_done", 32'(done), 1);
        chk("038_burst_q", 32'(q), 32'h08);
        step();
        // randomized traffic
        repeat (800) begin
            clr     = $urandom_range(99) != 0;
            load    = $urandom_range(19) == 0;
            start   = $urandom_range(5) == 0;
            sft     = 1'($urandom);
            mode    = 2'($urandom);
            nbits   = 4'($urandom_range(12));
            ph_low  = 1'($urandom);
            pl_high = 1'($urandom);
            dpl     = 8'($urandom);
            step();
        end
        clr = 1; load = 0; start = 0; sft = 0;
        step();
        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
